load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequential initiator for the core's word-addressed data memory. It accepts one load or store request from the execute stage, decodes RV32I `funct3`, and drives `MemRead`/`MemWrite`/`address`/`WriteData` on the memory bus. It extracts and sign- or zero-extends sub-word load data, and performs read-modify-write for byte and halfword stores. It sits between the ALU result / rs2 path and the data memory, replacing the direct control-unit drive of the memory strobes.

## Interface
- `Width`, 32, datapath and memory address/data width
- `clk`  input  1  clock; all state changes on rising edge
- `reset`  input  1  synchronous, active-high reset
- `start`  input  1  request strobe; sampled only in IDLE
- `is_store`  input  1  1 = store, 0 = load
- `funct3`  input  3  RV32I size/sign code
- `byte_addr`  input  Width  byte address (ALU result)
- `store_data`  input  Width  rs2 value
- `busy`  output  1  high in any state other than IDLE
- `done`  output  1  one-cycle completion pulse
- `err`  output  1  valid with `done`; misaligned access or illegal `funct3`
- `load_data`  output  Width  extended load result; held until the next completed load
- `MemRead`  output  1  memory read strobe
- `MemWrite`  output  1  memory write strobe
- `address`  output  Width  word index = `{2'b00, byte_addr[Width-1:2]}`
- `WriteData`  output  Width  full word to write
- `ReadData`  input  Width  memory word; combinational from `address`

## Operation
- On `start` in IDLE, register `is_store`, `funct3`, `byte_addr` and `store_data`. Later input changes have no effect.
- Legal loads: `funct3` = 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Every other code is illegal and sets `err`.
- Misaligned access sets `err`:
  - halfword with `byte_addr[0]`=1
  - word with `byte_addr[1:0]`≠0
- Error requests never assert `MemRead` or `MemWrite`.
- FSM states: IDLE, READ, WRITE, DONE, ERR.
  - IDLE→ERR on an illegal or misaligned request.
  - IDLE→READ on a load or an SB/SH store.
  - IDLE→WRITE on SW.
  - READ→DONE for a load; READ→WRITE for SB/SH.
  - WRITE→DONE.
  - DONE→IDLE and ERR→IDLE unconditionally.
- `MemRead`=1 only in READ, and `MemWrite`=1 only in WRITE. Both are decoded from the state register alone, so they are never both high and never glitch.
- `address` and `WriteData` are registered and stay stable for the whole strobe cycle. `address` holds its last value in other states.
- READ captures `ReadData` on the closing edge into an internal word register.
- Load extraction: select byte lane `byte_addr[1:0]` or half lane `byte_addr[1]`. Sign-extend for LB/LH; zero-extend for LBU/LHU; LW passes the word through.
- Store merge:
  - SB replaces byte lane `byte_addr[1:0]` of the captured word with `store_data[7:0]`.
  - SH replaces half lane `byte_addr[1]` with `store_data[15:0]`.
  - SW writes `store_data` unmodified.
- `load_data` updates in the READ→DONE transition for loads only. Stores and errors leave it unchanged.
- `start` while `busy`=1 is ignored; there is no queueing.

## Timing
- Request sampled at edge E0 (IDLE, `start`=1).
- Load: READ during cycle after E0, `done`=1 the following cycle. `done` comes 2 cycles after the `start` cycle.
- SW: WRITE for one cycle, then DONE. Latency is 2.
- SB/SH: READ, WRITE, DONE. Latency is 3.
- Error: ERR with `done`=1 and `err`=1 one cycle after the `start` cycle. Latency is 1.
- `done` and `err` are high for exactly one cycle. `err`=0 whenever `done`=0.
- Back-to-back: a new `start` is accepted in the IDLE cycle right after DONE or ERR. Minimum request spacing is therefore latency+1 cycles.
- Reset values: state IDLE, and `busy`, `done`, `err`, `MemRead`, `MemWrite`, `address`, `WriteData`, `load_data` all 0.
- Reset mid-operation (including during WRITE) forces IDLE at that edge. Strobes are 0 from the next cycle, and no `done` is issued for the aborted request.

## Test plan
- Preload word 5 = 0x8081_8283. LB at `byte_addr` 0x15 → `address`=5, `load_data`=0xFFFF_FF82 with `done` 2 cycles after `start`. LBU at the same address → 0x0000_0082.
- LH at 0x16 → 0xFFFF_8081. LW at 0x14 → 0x8081_8283, with `MemWrite` never asserted.
- SB of `store_data` 0x0000_00AA at 0x15 over 0x8081_8283 → one READ cycle, then a WRITE cycle with `WriteData`=0x8081_AA83, `done` at 3 cycles. A following LW reads 0x8081_AA83.
- SW of 0xDEAD_BEEF at 0x20 → `MemWrite`=1 for exactly one cycle with `address`=8. A following LW returns 0xDEAD_BEEF.
- LW at 0x22, SH at 0x23 and `funct3`=011 → `done`=`err`=1 one cycle after `start`, no strobes, and `load_data` unchanged.
- Assert `reset` during the WRITE cycle of an SB → next cycle is IDLE with all outputs 0 and no `done`. `start` pulsed while `busy` is ignored.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus bundle for the load/store unit.
// The master side is the LSU; the slave side is the execute stage plus the memory.
interface load_store_unit_if #(
  parameter int Width = 32
);
  logic             start;
  logic             is_store;
  logic [2:0]       funct3;
  logic [Width-1:0] byte_addr;
  logic [Width-1:0] store_data;
  logic             busy;
  logic             done;
  logic             err;
  logic [Width-1:0] load_data;
  logic             MemRead;
  logic             MemWrite;
  logic [Width-1:0] address;
  logic [Width-1:0] WriteData;
  logic [Width-1:0] ReadData;

  modport master (
    input  start, is_store, funct3, byte_addr, store_data, ReadData,
    output busy, done, err, load_data, MemRead, MemWrite, address, WriteData
  );

  modport slave (
    output start, is_store, funct3, byte_addr, store_data, ReadData,
    input  busy, done, err, load_data, MemRead, MemWrite, address, WriteData
  );
endinterface

// File: rtl/load_store_unit.sv
// Sequential RV32I load/store initiator for a word-addressed data memory:
// sub-word load extraction with sign/zero extension, read-modify-write for SB/SH.
module load_store_unit #(
  parameter int Width = 32
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

  state_t           state, state_nx;
  logic             req_store;
  logic [2:0]       req_f3;
  logic [1:0]       req_lane;
  logic [Width-1:0] req_data;
  logic [Width-1:0] address_q, write_data_q, load_data_q;
  logic             legal, misaligned, req_bad;

  function automatic logic [Width-1:0] extract(input logic [Width-1:0] w,
                                               input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lane +: 8];
    h = w[16*lane[1] +: 16];
    case (f3[1:0])
      2'b00:   extract = {{(Width-8){b[7] & ~f3[2]}}, b};
      2'b01:   extract = {{(Width-16){h[15] & ~f3[2]}}, h};
      default: extract = w;
    endcase
  endfunction

  function automatic logic [Width-1:0] merge(input logic [Width-1:0] w,
                                             input logic [Width-1:0] d,
                                             input logic [2:0] f3,
                                             input logic [1:0] lane);
    merge = w;
    case (f3[1:0])
      2'b00:   merge[8*lane +: 8] = d[7:0];
      2'b01:   merge[16*lane[1] +: 16] = d[15:0];
      default: merge = d;
    endcase
  endfunction

  // Request decode looks at the live inputs; it only matters in the start cycle.
  always_comb begin
    if (bus.is_store) legal = bus.funct3 inside {3'b000, 3'b001, 3'b010};
    else              legal = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misaligned = (bus.funct3[1:0] == 2'b01 && bus.byte_addr[0]) ||
                 (bus.funct3[1:0] == 2'b10 && bus.byte_addr[1:0] != 2'b00);
    req_bad    = !legal || misaligned;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (req_bad)                                  state_nx = ERR;
          else if (bus.is_store && bus.funct3 == 3'b010) state_nx = WRITE;
          else                                          state_nx = READ;
        end
      end
      READ:    state_nx = req_store ? WRITE : DONE;
      WRITE:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      req_store    <= 1'b0;
      req_f3       <= '0;
      req_lane     <= '0;
      req_data     <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      load_data_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.start) begin
        req_store <= bus.is_store;
        req_f3    <= bus.funct3;
        req_lane  <= bus.byte_addr[1:0];
        req_data  <= bus.store_data;
        if (!req_bad) begin
          address_q <= {2'b00, bus.byte_addr[Width-1:2]};
          // SW skips the read, so its write word is ready at acceptance.
          if (bus.is_store) write_data_q <= bus.store_data;
        end
      end
      if (state == READ) begin
        if (req_store) write_data_q <= merge(bus.ReadData, req_data, req_f3, req_lane);
        else           load_data_q  <= extract(bus.ReadData, req_f3, req_lane);
      end
    end
  end

  // Strobes and status decode from the state register only.
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE) || (state == ERR);
  assign bus.err       = (state == ERR);
  assign bus.MemRead   = (state == READ);
  assign bus.MemWrite  = (state == WRITE);
  assign bus.address   = address_q;
  assign bus.WriteData = write_data_q;
  assign bus.load_data = load_data_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural word memory.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] mem [64];

  load_store_unit_if #(.Width(32)) bus ();
  load_store_unit #(.Width(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  assign bus.ReadData = (bus.address < 32'd64) ? mem[bus.address[5:0]] : 32'h0;
  always @(posedge clk) if (bus.MemWrite && bus.address < 32'd64) mem[bus.address[5:0]] <= bus.WriteData;

  // Issues one request from an IDLE cycle and observes it until done (bounded).
  task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output int rds, output int wrs,
                     output logic [31:0] ra, output logic [31:0] wa, output logic [31:0] wd,
                     output logic er);
    bus.start = 1'b1; bus.is_store = st; bus.funct3 = f3; bus.byte_addr = a; bus.store_data = d;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.is_store = 1'b0; bus.funct3 = 3'b111; bus.byte_addr = 32'hFFFF_FFFF;
    lat = 0; rds = 0; wrs = 0; ra = 'x; wa = 'x; wd = 'x; er = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (bus.MemRead)  begin rds++; ra = bus.address; end
      if (bus.MemWrite) begin wrs++; wa = bus.address; wd = bus.WriteData; end
      if (bus.done) begin lat = k; er = bus.err; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.is_store = 1'b0; bus.funct3 = 3'b000; bus.byte_addr = '0; bus.store_data = '0;
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.err, bus.MemRead, bus.MemWrite} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctl got %b expected 00000", {bus.busy, bus.done, bus.err, bus.MemRead, bus.MemWrite});
    end
    n_checks++;
    if ({bus.address, bus.WriteData, bus.load_data} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data got %h %h %h expected 0", bus.address, bus.WriteData, bus.load_data);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    int lat, rds, wrs; logic [31:0] ra, wa, wd; logic er;
    logic [31:0] exp_ld [4];
    logic [2:0]  f3s [4];
    logic [31:0] as [4];
    exp_ld = '{32'hFFFF_FF82, 32'h0000_0082, 32'hFFFF_8081, 32'h8081_8283};
    f3s    = '{3'b000, 3'b100, 3'b001, 3'b010};
    as     = '{32'h15, 32'h15, 32'h16, 32'h14};
    for (int i = 0; i < 4; i++) begin
      run(1'b0, f3s[i], as[i], 32'h0, lat, rds, wrs, ra, wa, wd, er);
      n_checks++;
      if (bus.load_data !== exp_ld[i]) begin
        n_fail++; $display("FAIL load%0d_data got %h expected %h", i, bus.load_data, exp_ld[i]);
      end
      n_checks++;
      if ({lat, rds, wrs, er} !== {32'd2, 32'd1, 32'd0, 1'b0}) begin
        n_fail++; $display("FAIL load%0d_timing got lat=%0d rd=%0d wr=%0d err=%b expected 2 1 0 0", i, lat, rds, wrs, er);
      end
      n_checks++;
      if (ra !== 32'd5) begin
        n_fail++; $display("FAIL load%0d_addr got %h expected 5", i, ra);
      end
    end
  endtask

  task automatic test_store_byte();
    int lat, rds, wrs; logic [31:0] ra, wa, wd; logic er;
    run(1'b1, 3'b000, 32'h15, 32'h0000_00AA, lat, rds, wrs, ra, wa, wd, er);
    n_checks++;
    if ({lat, rds, wrs, er} !== {32'd3, 32'd1, 32'd1, 1'b0}) begin
      n_fail++; $display("FAIL sb_timing got lat=%0d rd=%0d wr=%0d err=%b expected 3 1 1 0", lat, rds, wrs, er);
    end
    n_checks++;
    if (wd !== 32'h8081_AA83 || wa !== 32'd5) begin
      n_fail++; $display("FAIL sb_write got %h@%h expected 8081aa83@5", wd, wa);
    end
    n_checks++;
    if (bus.load_data !== 32'h8081_8283) begin
      n_fail++; $display("FAIL sb_keeps_load got %h expected 80818283", bus.load_data);
    end
    run(1'b0, 3'b010, 32'h14, 32'h0, lat, rds, wrs, ra, wa, wd, er);
    n_checks++;
    if (bus.load_data !== 32'h8081_AA83) begin
      n_fail++; $display("FAIL sb_readback got %h expected 8081aa83", bus.load_data);
    end
  endtask

  task automatic test_store_word_half();
    int lat, rds, wrs; logic [31:0] ra, wa, wd; logic er;
    run(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, lat, rds, wrs, ra, wa, wd, er);
    n_checks++;
    if ({lat, rds, wrs, er} !== {32'd2, 32'd0, 32'd1, 1'b0} || wa !== 32'd8 || wd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL sw got lat=%0d rd=%0d wr=%0d err=%b %h@%h expected 2 0 1 0 deadbeef@8", lat, rds, wrs, er, wd, wa);
    end
    run(1'b0, 3'b010, 32'h20, 32'h0, lat, rds, wrs, ra, wa, wd, er);
    n_checks++;
    if (bus.load_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL sw_readback got %h expected deadbeef", bus.load_data);
    end
    run(1'b1, 3'b001, 32'h22, 32'hFFFF_1234, lat, rds, wrs, ra, wa, wd, er);
    n_checks++;
    if ({lat, rds, wrs} !== {32'd3, 32'd1, 32'd1} || wd !== 32'h1234_BEEF) begin
      n_fail++; $display("FAIL sh got lat=%0d rd=%0d wr=%0d wd=%h expected 3 1 1 1234beef", lat, rds, wrs, wd);
    end
    run(1'b0, 3'b101, 32'h22, 32'h0, lat, rds, wrs, ra, wa, wd, er);
    n_checks++;
    if (bus.load_data !== 32'h0000_1234) begin
      n_fail++; $display("FAIL lhu got %h expected 00001234", bus.load_data);
    end
  endtask

  task automatic test_errors();
    int lat, rds, wrs; logic [31:0] ra, wa, wd; logic er;
    logic        sts [3];
    logic [2:0]  f3s [3];
    logic [31:0] as  [3];
    sts = '{1'b0, 1'b1, 1'b0};
    f3s = '{3'b010, 3'b001, 3'b011};
    as  = '{32'h22, 32'h23, 32'h20};
    for (int i = 0; i < 3; i++) begin
      run(sts[i], f3s[i], as[i], 32'h5555_5555, lat, rds, wrs, ra, wa, wd, er);
      n_checks++;
      if ({lat, rds, wrs, er} !== {32'd1, 32'd0, 32'd0, 1'b1}) begin
        n_fail++; $display("FAIL err%0d got lat=%0d rd=%0d wr=%0d err=%b expected 1 0 0 1", i, lat, rds, wrs, er);
      end
      n_checks++;
      if (bus.load_data !== 32'h0000_1234 || bus.err !== 1'b0 || bus.done !== 1'b0) begin
        n_fail++; $display("FAIL err%0d_after got ld=%h err=%b done=%b expected 00001234 0 0", i, bus.load_data, bus.err, bus.done);
      end
    end
  endtask

  task automatic test_reset_mid_and_busy();
    int dones, wrs, lat;
    bus.start = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b000; bus.byte_addr = 32'h15; bus.store_data = 32'hAA;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.MemWrite !== 1'b1) begin
      n_fail++; $display("FAIL mid_in_write got MemWrite=%b expected 1", bus.MemWrite);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if ({bus.busy, bus.done, bus.err, bus.MemRead, bus.MemWrite} !== 5'b0 ||
        {bus.address, bus.WriteData, bus.load_data} !== 96'h0) begin
      n_fail++; $display("FAIL mid_reset got ctl=%b %h %h %h expected all 0",
        {bus.busy, bus.done, bus.err, bus.MemRead, bus.MemWrite}, bus.address, bus.WriteData, bus.load_data);
    end
    dones = 0;
    repeat (3) begin @(posedge clk); #1; if (bus.done) dones++; end
    n_checks++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL mid_no_done got %0d done pulses expected 0", dones);
    end
    // LW accepted, then start held high with SW fields while busy.
    bus.start = 1'b1; bus.is_store = 1'b0; bus.funct3 = 3'b010; bus.byte_addr = 32'h14;
    @(posedge clk); #1;
    bus.is_store = 1'b1; bus.byte_addr = 32'h20; bus.store_data = 32'h1111_1111;
    wrs = 0; lat = 0;
    for (int k = 1; k <= 8; k++) begin
      if (bus.MemWrite) wrs++;
      if (bus.done) begin lat = k; break; end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({lat, wrs} !== {32'd2, 32'd0} || bus.load_data !== 32'h8081_AA83) begin
      n_fail++; $display("FAIL busy_ignore got lat=%0d wr=%0d ld=%h expected 2 0 8081aa83", lat, wrs, bus.load_data);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || mem[8] !== 32'h1234_BEEF) begin
      n_fail++; $display("FAIL busy_no_queue got busy=%b mem8=%h expected 0 1234beef", bus.busy, mem[8]);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[5] = 32'h8081_8283;
    test_reset();
    test_loads();
    test_store_byte();
    test_store_word_half();
    test_errors();
    test_reset_mid_and_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
